// File: rtl/frame_char_recv_if.sv
// Bundles the byte-strobe input and the decoded-frame outputs of the status frame parser.
// slave: the parser consumes bytes and drives results; master: the UART-side/host-side user.
interface frame_char_recv_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] frame_str;
  logic [3:0]  frame_digit;
  logic        frame_valid;
  logic        frame_err;
  logic [1:0]  frame_err_code;
  logic [15:0] good_cnt;
  logic [7:0]  err_cnt;

  modport slave (
    input  rx_data, rx_valid,
    output frame_str, frame_digit, frame_valid, frame_err, frame_err_code, good_cnt, err_cnt
  );

  modport master (
    output rx_data, rx_valid,
    input  frame_str, frame_digit, frame_valid, frame_err, frame_err_code, good_cnt, err_cnt
  );
endinterface

// File: rtl/frame_char_recv.sv
// Receive-side parser for the 11-byte UART status frame: 22 | 4 flag bytes | y | x1 | x2 | FF | digit | 55.
// Optional macro FRAME_RANGE_CHECK_EN rejects fields whose unused upper bits are non-zero.
module frame_char_recv #(
  parameter logic [7:0]  HDR_BYTE    = 8'h22,
  parameter logic [7:0]  SEP_BYTE    = 8'hFF,
  parameter logic [7:0]  TRL_BYTE    = 8'h55,
  parameter int unsigned TIMEOUT_CYC = 500_000
) (
  input logic              clk,
  input logic              rst_n,
  frame_char_recv_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, FIELD, SEP, DIGIT, TRAIL} state_e;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   shStr_q, shStr_d;
  logic [3:0]    shDig_q, shDig_d;
  logic [15:0]   str_q, str_d;
  logic [3:0]    dig_q, dig_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [15:0]   good_q, good_d;
  logic [7:0]    errCnt_q, errCnt_d;

  logic          commit;
  logic          abort;
  logic [1:0]    abortCode;
  logic          bitBad;
  logic          nibBad;
  logic [7:0]    rxData;

  assign rxData = bus.rx_data;

`ifdef FRAME_RANGE_CHECK_EN
  assign bitBad = |rxData[7:1];
  assign nibBad = |rxData[7:4];
`else
  assign bitBad = 1'b0;
  assign nibBad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tmo_q    <= '0;
      shStr_q  <= '0;
      shDig_q  <= '0;
      str_q    <= '0;
      dig_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      good_q   <= '0;
      errCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      shStr_q  <= shStr_d;
      shDig_q  <= shDig_d;
      str_q    <= str_d;
      dig_q    <= dig_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      code_q   <= code_d;
      good_q   <= good_d;
      errCnt_q <= errCnt_d;
    end
  end

  // A mismatched separator/trailer that is itself a header restarts a frame immediately.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    shStr_d   = shStr_q;
    shDig_d   = shDig_q;
    commit    = 1'b0;
    abort     = 1'b0;
    abortCode = 2'b00;
    if (bus.rx_valid) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          if (rxData == HDR_BYTE) begin
            state_d = FIELD;
            idx_d   = 4'd1;
          end
        end
        FIELD: begin
          if ((idx_q <= 4'd4) ? bitBad : nibBad) begin
            abort     = 1'b1;
            abortCode = 2'b11;
            state_d   = IDLE;
            idx_d     = '0;
          end else begin
            case (idx_q)
              4'd1:    shStr_d[15]   = rxData[0];
              4'd2:    shStr_d[14]   = rxData[0];
              4'd3:    shStr_d[13]   = rxData[0];
              4'd4:    shStr_d[12]   = rxData[0];
              4'd5:    shStr_d[11:8] = rxData[3:0];
              4'd6:    shStr_d[7:4]  = rxData[3:0];
              default: shStr_d[3:0]  = rxData[3:0];
            endcase
            if (idx_q == 4'd7) begin
              state_d = SEP;
              idx_d   = 4'd8;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        SEP: begin
          if (rxData == SEP_BYTE) begin
            state_d = DIGIT;
            idx_d   = 4'd9;
          end else begin
            abort     = 1'b1;
            abortCode = 2'b01;
            state_d   = (rxData == HDR_BYTE) ? FIELD : IDLE;
            idx_d     = (rxData == HDR_BYTE) ? 4'd1 : 4'd0;
          end
        end
        DIGIT: begin
          if (nibBad) begin
            abort     = 1'b1;
            abortCode = 2'b11;
            state_d   = IDLE;
            idx_d     = '0;
          end else begin
            shDig_d = rxData[3:0];
            state_d = TRAIL;
            idx_d   = 4'd10;
          end
        end
        default: begin
          if (rxData == TRL_BYTE) begin
            commit  = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            abort     = 1'b1;
            abortCode = 2'b01;
            state_d   = (rxData == HDR_BYTE) ? FIELD : IDLE;
            idx_d     = (rxData == HDR_BYTE) ? 4'd1 : 4'd0;
          end
        end
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        abort     = 1'b1;
        abortCode = 2'b10;
        state_d   = IDLE;
        idx_d     = '0;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Visible results move only on commit/abort; both counters stick at all-ones.
  always_comb begin
    str_d    = str_q;
    dig_d    = dig_q;
    code_d   = code_q;
    good_d   = good_q;
    errCnt_d = errCnt_q;
    valid_d  = commit;
    err_d    = abort;
    if (commit) begin
      str_d = shStr_q;
      dig_d = shDig_q;
      if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
    end
    if (abort) begin
      code_d = abortCode;
      if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
    end
  end

  assign bus.frame_str      = str_q;
  assign bus.frame_digit    = dig_q;
  assign bus.frame_valid    = valid_q;
  assign bus.frame_err      = err_q;
  assign bus.frame_err_code = code_q;
  assign bus.good_cnt       = good_q;
  assign bus.err_cnt        = errCnt_q;

endmodule
